// File: rtl/inst_cache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
// Lines are one 32-bit word; the address splits into tag | index | byte offset.
package inst_cache_pkg;

  // Cache geometry and address split.
  localparam int INDEX_BITS = 8;
  localparam int ADDR_W     = 32;
  localparam int INST_W     = 32;
  localparam int LINES      = 1 << INDEX_BITS;
  localparam int IDX_LO     = 2;
  localparam int IDX_HI     = INDEX_BITS + 1;
  localparam int TAG_LO     = INDEX_BITS + 2;
  localparam int TAG_W      = ADDR_W - TAG_LO;

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [INST_W-1:0] INST_ZERO = '0;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_MISS = 1'b1
  } icache_state_t;

  // Byte address to the word-aligned address sent to the memory controller.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// Fetch: fetch_en_i is a level held with a stable address until the one-cycle
// fetch_valid_o pulse. Memory: mem_req_o is a level held until the one-cycle
// mem_done_i pulse, which carries mem_data_i; the request drops on that edge.
interface inst_cache_if;
  import inst_cache_pkg::*;

  logic              fetch_en_i;
  logic [ADDR_W-1:0] fetch_addr_i;
  logic              fetch_valid_o;
  logic [INST_W-1:0] fetch_inst_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_done_i;
  logic [INST_W-1:0] mem_data_i;

  // Cache side.
  modport slave (
    input  fetch_en_i, fetch_addr_i, mem_done_i, mem_data_i,
    output fetch_valid_o, fetch_inst_o, mem_req_o, mem_addr_o
  );

  // Fetch stage plus memory controller side.
  modport master (
    output fetch_en_i, fetch_addr_i, mem_done_i, mem_data_i,
    input  fetch_valid_o, fetch_inst_o, mem_req_o, mem_addr_o
  );

endinterface

// File: rtl/inst_cache_array.sv
// Tag/valid/data storage: combinational hit/data read, single synchronous write port.
// Only the valid bits are reset; tag and data contents are don't-care until filled.
module inst_cache_array
  import inst_cache_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] rd_idx,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  hit,
  output logic [INST_W-1:0]     rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [INST_W-1:0]     wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [INST_W-1:0] data_q [LINES];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: IDLE serves hits, MISS waits on the memory
// controller and fills. A pipeline clear abandons any in-flight miss.
module inst_cache
  import inst_cache_pkg::*;
(
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          clear,
  inst_cache_if.slave   bus,
  output icache_state_t dbg_state
);

  icache_state_t     state_q, state_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [INST_W-1:0] fetch_inst_q, fetch_inst_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              fill_we;
  logic              arr_hit;
  logic [INST_W-1:0] arr_data;

  // Fill index/tag come from the latched miss address, so an address change
  // during MISS cannot redirect the fill.
  inst_cache_array u_array (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_idx  (bus.fetch_addr_i[IDX_HI:IDX_LO]),
    .rd_tag  (bus.fetch_addr_i[ADDR_W-1:TAG_LO]),
    .hit     (arr_hit),
    .rd_data (arr_data),
    .we      (fill_we && rdy_in && !rst_in),
    .wr_idx  (mem_addr_q[IDX_HI:IDX_LO]),
    .wr_tag  (mem_addr_q[ADDR_W-1:TAG_LO]),
    .wr_data (bus.mem_data_i)
  );

  always_comb begin
    state_d       = state_q;
    fetch_valid_d = 1'b0;
    fetch_inst_d  = fetch_inst_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    fill_we       = 1'b0;

    unique case (state_q)
      ICACHE_IDLE: begin
        // A request still high in the cycle of its own response is not re-sampled.
        if (bus.fetch_en_i && !fetch_valid_q) begin
          if (arr_hit) begin
            fetch_valid_d = 1'b1;
            fetch_inst_d  = arr_data;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = word_align(bus.fetch_addr_i);
            state_d    = ICACHE_MISS;
          end
        end
      end
      ICACHE_MISS: begin
        if (bus.mem_done_i) begin
          fill_we       = 1'b1;
          fetch_valid_d = 1'b1;
          fetch_inst_d  = bus.mem_data_i;
          mem_req_d     = 1'b0;
          state_d       = ICACHE_IDLE;
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase

    // A flush overrides everything, including a completion on the same edge.
    if (clear) begin
      fill_we       = 1'b0;
      fetch_valid_d = 1'b0;
      fetch_inst_d  = fetch_inst_q;
      mem_req_d     = 1'b0;
      state_d       = ICACHE_IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ICACHE_IDLE;
      fetch_valid_q <= 1'b0;
      fetch_inst_q  <= INST_ZERO;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
    end else if (rdy_in) begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_inst_q  <= fetch_inst_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  assign bus.fetch_valid_o = fetch_valid_q;
  assign bus.fetch_inst_o  = fetch_inst_q;
  assign bus.mem_req_o     = mem_req_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign dbg_state         = state_q;

endmodule
